check_responder: RTL
====================

# check_responder

Far end of the check/done handshake: consumes the level-held pending flag (`check`) and runs a memory compare job. The job reads `len` words from a read port and compares each against a reference word. It then returns a one-cycle `done` pulse that clears the flag, and latches the pass/fail result. It sits beside the check flag register in the project datapath, between the controller that raises check requests and the buffer memory under test.

## Interface
- DATA_W, 32, width of compared words
- ADDR_W, 8, read address width; also width of job length
- RD_LAT, 1, fixed read latency in cycles (1..4) from `rd_en_o` to valid `rd_data_i`/`ref_data_i`
- ERR_W, 8, width of saturating mismatch counter

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- check_i  in  1  pending-check level from the check flag register
- base_addr_i  in  ADDR_W  first address, sampled on job start
- len_i  in  ADDR_W  word count, sampled on job start; 0 is legal
- rd_en_o  out  1  read strobe, one address per cycle
- rd_addr_o  out  ADDR_W  read address
- rd_data_i  in  DATA_W  data under test, valid RD_LAT cycles after strobe
- ref_data_i  in  DATA_W  expected data, same timing as rd_data_i
- busy_o  out  1  high in every non-IDLE state
- done_o  out  1  one-cycle pulse ending a job; drives the flag's done input
- pass_o  out  1  1 when last job had zero mismatches
- err_cnt_o  out  ERR_W  mismatch count of last job, saturating

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE with `check_i`=1 does the following: latch base/len, clear err_cnt, and set pass=0. If len=0, go to DONE. Otherwise go to ISSUE.
- ISSUE: `rd_en_o`=1 and `rd_addr_o` = base + k for k = 0..len-1. Address wraps modulo 2^ADDR_W. After the last issue, go to DRAIN.
- Valid pipeline: an RD_LAT-deep shift register of `rd_en_o`. When its tail is 1, compare `rd_data_i` with `ref_data_i`. On mismatch, err_cnt += 1, saturating at 2^ERR_W−1.
- DRAIN: wait until the valid pipeline is empty and the last compare has been counted, then go to DONE.
- DONE: `done_o`=1 for one cycle. Drive `pass_o` = (err_cnt==0), with the final count included. Return to IDLE.
- `check_i` is ignored outside IDLE.
- A re-raise of the flag coincident with done keeps the flag set, because set has priority in the flag register. In that case the next job starts from IDLE.
- `pass_o` and `err_cnt_o` hold from DONE until the next job start.
- Reset, including mid-job: state IDLE, all outputs 0. The valid pipeline and counters are cleared, and in-flight reads are discarded.

## Timing
- Reset values: `rd_en_o`=0, `rd_addr_o`=0, `busy_o`=0, `done_o`=0, `pass_o`=0, `err_cnt_o`=0.
- `check_i` is high in cycle T while in IDLE. The first `rd_en_o` appears in T+1 and `busy_o` rises in T+1.
- Job length N≥1:
  - `rd_en_o` is high in cycles T+1..T+N.
  - The last compare happens in cycle T+N+RD_LAT.
  - `done_o` is high in T+N+RD_LAT+1.
  - Total latency from request to done: N+RD_LAT+1 cycles.
- N=0: `done_o` is high in T+1 and `pass_o`=1.
- The flag register clears on the edge that ends the `done_o` cycle, so IDLE sees `check_i`=0 the next cycle. The block never double-starts.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Shared package `check_pkg`:
  - FSM state enum (IDLE/ISSUE/DRAIN/DONE).
  - Default widths DATA_W/ADDR_W/ERR_W.
  - RD_LAT bounds.
- One natural sub-module: `sat_counter` (ERR_W, clear, inc, saturate). Reusable by other checkers.
- The valid shift register and FSM stay inline.

## Test plan
- Clean job, RD_LAT=1: base=0x10, len=4, ref==data. Required response:
  - addresses 0x10..0x13 in T+1..T+4;
  - `done_o` pulse at T+6;
  - `pass_o`=1, `err_cnt_o`=0.
- Mismatches, RD_LAT=2: len=8, with words 2 and 5 corrupted. Required response: done at T+11, `pass_o`=0, `err_cnt_o`=2.
- Zero length and wrap-around:
  - len=0 gives `done_o` at T+1 and `pass_o`=1, with no `rd_en_o`.
  - base=0xFE, len=4 gives addresses FE, FF, 00, 01.
- Saturation: ERR_W=2, len=6, all mismatching gives `err_cnt_o`=3 and `pass_o`=0.
- Back-to-back: re-raise check in the done cycle. Required response:
  - the second job starts exactly 2 cycles after the first `done_o`;
  - the previous result holds until that start.
- Reset mid-job: assert `rst_n`=0 during ISSUE of a len=8 job. Required response: all outputs 0 immediately, and no `done_o` after release until a new `check_i`.

Source files
------------

// File: rtl/check_pkg.sv
// Shared types and defaults for the check/done responder and related checkers.
// Widths here are defaults only; instances override through parameters.
package check_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_ERR_W  = 8;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Keep the valid pipeline depth inside the range the read port supports.
  function automatic int clamp_lat(input int lat);
    if (lat < RD_LAT_MIN) return RD_LAT_MIN;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Output is the registered count, updated one cycle after clr_i/inc_i.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/check_responder.sv
// Consumes the level-held check flag, streams len reads and compares them against reference data.
// Request to done is len+RD_LAT+1 cycles (1 for len=0); no backpressure, one address per cycle.
module check_responder
  import check_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = 1,
  parameter int ERR_W  = DEF_ERR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              check_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic [DATA_W-1:0] ref_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ERR_W-1:0]  err_cnt_o
);

  localparam int LAT = clamp_lat(RD_LAT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [LAT-1:0]    vld_pipe_q, vld_pipe_d;
  logic [LAT-1:0]    vld_shift;
  logic              drained;
  logic              err_clr;
  logic              err_inc;
  logic [ERR_W-1:0]  err_cnt;

  // The tail bit marks the cycle whose read data is valid; everything else is still in flight.
  assign vld_shift  = vld_pipe_q << 1;
  assign vld_pipe_d = vld_shift | LAT'(rd_en_q);
  assign drained    = (vld_shift == '0);
  assign err_inc    = vld_pipe_q[LAT-1] && (rd_data_i != ref_data_i);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_clr   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (check_i) begin
          len_d     = len_i;
          idx_d     = '0;
          rd_addr_d = base_addr_i;
          err_clr   = 1'b1;
          if (len_i == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_ISSUE;
            rd_en_d = 1'b1;
            pass_d  = 1'b0;
          end
        end
      end
      ST_ISSUE: begin
        if (idx_q == (len_q - ADDR_W'(1))) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d     = idx_q + ADDR_W'(1);
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          rd_en_d   = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Leave once only the tail remains, folding its compare into the result.
        if (drained) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (err_cnt == '0) && !err_inc;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (err_clr),
    .inc_i (err_inc),
    .cnt_o (err_cnt)
  );

  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = rd_addr_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign err_cnt_o = err_cnt;

endmodule
